root_arbiter: RTL and testbench
===============================

ROOT_ARBITER -- requirements
Module: root_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, engine-wait limit in cycles (8-bit, 1..255), used only with ROOT_ARB_TIMEOUT_EN.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: reqN_valid  in  1  requester N (N=0,1) has an operation pending.
REQ-006 Port: reqN_ready  out  1  requester N operation accepted this cycle when valid also high.
REQ-007 Port: reqN_data_1  in  10  radicand for requester N.
REQ-008 Port: reqN_data_2  in  3  root degree for requester N.
REQ-009 Port: eng_in_valid  out  1  one-cycle start pulse to the shared root engine.
REQ-010 Port: eng_in_data_1  out  10  radicand to engine.
REQ-011 Port: eng_in_data_2  out  3  degree to engine.
REQ-012 Port: eng_out_valid  in  1  engine result strobe.
REQ-013 Port: eng_out_data  in  20  engine result.
REQ-014 Port: rsp_valid  out  1  one-cycle result pulse, no backpressure.
REQ-015 Port: rsp_id  out  1  requester that owns the result.
REQ-016 Port: rsp_data  out  20  result value.
REQ-017 Port: rsp_err  out  1  result aborted by timeout.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one operation in flight at a time.
REQ-019 IDLE: reqN_ready SHALL be high only for the granted requester (combinational from valids and pointer); all ready low in other states.
REQ-020 Arbitration SHALL be round-robin: if both valid, grant the requester not served last; if one valid, grant it.
REQ-021 On accept (valid and ready), operands and id SHALL be latched and FSM -> ISSUE; last-served pointer updated same edge.
REQ-022 ISSUE: eng_in_valid high exactly one cycle; FSM -> WAIT next cycle.
REQ-023 eng_in_data_1/2 SHALL hold latched operands stable from ISSUE through RESP; zero in IDLE.
REQ-024 WAIT: on eng_out_valid, capture eng_out_data, FSM -> RESP.
REQ-025 eng_out_valid in IDLE or ISSUE SHALL be ignored.
REQ-026 RESP: rsp_valid=1, rsp_id=latched id, rsp_data=captured value for one cycle; FSM -> IDLE; rsp_* zero whenever rsp_valid low.
REQ-027 Latency: accept at edge T -> eng_in_valid during cycle T+1; eng_out_valid sampled at edge E -> rsp_valid during cycle E+1.
REQ-028 New accept SHALL be possible in the cycle after RESP (no back-to-back overlap with RESP).
REQ-029 reqN_valid dropped before accept SHALL cancel without side effects.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, pointer = 1 (req0 wins first tie), all outputs 0, latched operands 0.
REQ-031 Reset mid-operation SHALL discard the in-flight operation with no rsp_valid; late eng_out_valid after reset ignored.

Configuration
REQ-032 Macro ROOT_ARB_TIMEOUT_EN defined: 8-bit counter cleared on WAIT entry, increments each WAIT cycle; at TIMEOUT_CYCLES without eng_out_valid -> RESP with rsp_err=1, rsp_data=0; eng_out_valid on the same cycle as expiry wins (rsp_err=0).
REQ-033 Macro undefined: no counter; WAIT lasts indefinitely; rsp_err tied 0.

Verification
REQ-034 req0 data_1=16,data_2=2; engine model returns 0x00080 after 30 cycles -> one eng_in_valid pulse with 16/2, rsp_valid one cycle, rsp_id=0, rsp_data=0x00080.
REQ-035 req0 and req1 valid same cycle from reset -> req0 served first, then req1; with both held continuously grants alternate 0,1,0,1.
REQ-036 Spurious eng_out_valid in IDLE -> no rsp_valid, no state change.
REQ-037 rst_n pulsed low during WAIT -> all outputs 0 immediately, no rsp_valid, next request served normally.
REQ-038 ROOT_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10, engine silent -> rsp_valid with rsp_err=1, rsp_data=0 ten WAIT cycles after ISSUE; undefined -> FSM remains in WAIT.

Source files
------------

// File: rtl/root_arbiter.sv
`timescale 1ns/1ps
// root_arbiter: two-requester round-robin front end for a shared root engine.
// One operation is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional feature: define ROOT_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles; the result is then flagged with rsp_err=1, rsp_data=0.
module root_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [9:0]  req0_data_1,
    input  logic [2:0]  req0_data_2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [9:0]  req1_data_1,
    input  logic [2:0]  req1_data_2,
    output logic        eng_in_valid,
    output logic [9:0]  eng_in_data_1,
    output logic [2:0]  eng_in_data_2,
    input  logic        eng_out_valid,
    input  logic [19:0] eng_out_data,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [19:0] rsp_data,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    logic   last_id;    // requester served most recently
    logic   cur_id;     // owner of the in-flight operation
    logic   grant_any;
    logic   grant_id;

`ifdef ROOT_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^8'(TIMEOUT_CYCLES);
    assign rsp_err = 1'b0;
`endif

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_id;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Ready only in IDLE, only for the granted requester, and never while reset is held.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && (state == IDLE)) begin
            req0_ready = req0_valid & ~grant_id;
            req1_ready = req1_valid &  grant_id;
        end
    end

    // Operation sequencer with registered engine and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_id       <= 1'b1;
            cur_id        <= 1'b0;
            eng_in_valid  <= 1'b0;
            eng_in_data_1 <= '0;
            eng_in_data_2 <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_data      <= '0;
`ifdef ROOT_ARB_TIMEOUT_EN
            rsp_err       <= 1'b0;
            wait_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cur_id        <= grant_id;
                        last_id       <= grant_id;
                        eng_in_data_1 <= grant_id ? req1_data_1 : req0_data_1;
                        eng_in_data_2 <= grant_id ? req1_data_2 : req0_data_2;
                        eng_in_valid  <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    eng_in_valid <= 1'b0;
`ifdef ROOT_ARB_TIMEOUT_EN
                    wait_cnt     <= '0;
`endif
                    state        <= WAIT;
                end
                WAIT: begin
                    if (eng_out_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_data  <= eng_out_data;
`ifdef ROOT_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        state     <= RESP;
`ifdef ROOT_ARB_TIMEOUT_EN
                    end else if (wait_cnt == TO_LAST) begin
                        // Engine result arriving on the expiry cycle takes the branch above.
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + 8'd1;
`endif
                    end
                end
                RESP: begin
                    rsp_valid     <= 1'b0;
                    rsp_id        <= 1'b0;
                    rsp_data      <= '0;
`ifdef ROOT_ARB_TIMEOUT_EN
                    rsp_err       <= 1'b0;
`endif
                    eng_in_data_1 <= '0;
                    eng_in_data_2 <= '0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_root_arbiter.sv
`timescale 1ns/1ps
// tb_root_arbiter: randomized self-checking bench with a transaction-level
// round-robin reference model. All drives and samples happen mid-cycle.
module tb_root_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [9:0]  req0_data_1, req1_data_1;
    logic [2:0]  req0_data_2, req1_data_2;
    logic        eng_in_valid;
    logic [9:0]  eng_in_data_1;
    logic [2:0]  eng_in_data_2;
    logic        eng_out_valid;
    logic [19:0] eng_out_data;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [19:0] rsp_data;

    int checks = 0;
    int errors = 0;
    int m_last = 1;    // model: requester served most recently

`ifdef ROOT_ARB_TIMEOUT_EN
    localparam int unsigned SINGLE_LAT = 9;
`else
    localparam int unsigned SINGLE_LAT = 30;
`endif

    root_arbiter #(.TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data_1(req0_data_1), .req0_data_2(req0_data_2),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data_1(req1_data_1), .req1_data_2(req1_data_2),
        .eng_in_valid(eng_in_valid), .eng_in_data_1(eng_in_data_1),
        .eng_in_data_2(eng_in_data_2),
        .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_grant(input logic v0, input logic v1);
        if (v0 && v1) return (m_last == 0) ? 1 : 0;
        return v0 ? 0 : 1;
    endfunction

    // One complete operation; engine answers in WAIT cycle 'lat'.
    task automatic run_op(input logic v0, input logic v1,
                          input logic [9:0] a0, input logic [2:0] d0,
                          input logic [9:0] a1, input logic [2:0] d1,
                          input int unsigned lat, input logic spur,
                          input logic hold, input logic [19:0] res,
                          output int g);
        logic [12:0] exp_ops;
        logic        gid;
        req0_valid = v0; req0_data_1 = a0; req0_data_2 = d0;
        req1_valid = v1; req1_data_1 = a1; req1_data_2 = d1;
        eng_out_valid = spur;
        eng_out_data  = 20'($urandom);
        #1;
        g   = model_grant(v0, v1);
        gid = (g == 1);
        checks++;
        if ({req1_ready, req0_ready} !== (gid ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL grant_ready got=%b exp=%b", {req1_ready, req0_ready}, gid ? 2'b10 : 2'b01);
        end
        m_last  = g;
        exp_ops = gid ? {a1, d1} : {a0, d0};
        @(negedge clk);
        if (!hold) begin
            if (gid) req1_valid = 1'b0; else req0_valid = 1'b0;
        end
        eng_out_valid = spur;
        #1;
        checks++;
        if (eng_in_valid !== 1'b1) begin
            errors++; $display("FAIL issue_pulse got=%b exp=1", eng_in_valid);
        end
        checks++;
        if ({eng_in_data_1, eng_in_data_2} !== exp_ops) begin
            errors++; $display("FAIL issue_ops got=%h exp=%h", {eng_in_data_1, eng_in_data_2}, exp_ops);
        end
        checks++;
        if ({req1_ready, req0_ready, rsp_valid} !== 3'b000) begin
            errors++; $display("FAIL issue_busy got=%b exp=000", {req1_ready, req0_ready, rsp_valid});
        end
        @(negedge clk);
        eng_out_valid = 1'b0;
        #1;
        checks++;
        if ({eng_in_valid, rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL wait_entry got=%b exp=00", {eng_in_valid, rsp_valid});
        end
        for (int i = 1; i < int'(lat); i++) begin
            @(negedge clk); #1;
            checks++;
            if ({eng_in_valid, rsp_valid, req1_ready, req0_ready, eng_in_data_1, eng_in_data_2}
                !== {4'b0000, exp_ops}) begin
                errors++;
                $display("FAIL wait_hold cyc=%0d got=%b/%h exp=0000/%h", i,
                         {eng_in_valid, rsp_valid, req1_ready, req0_ready},
                         {eng_in_data_1, eng_in_data_2}, exp_ops);
            end
        end
        eng_out_valid = 1'b1;
        eng_out_data  = res;
        @(negedge clk);
        eng_out_valid = 1'b0;
        eng_out_data  = 20'($urandom);
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, gid, res, 1'b0}) begin
            errors++;
            $display("FAIL resp got=v%b id%b d%h e%b exp=v1 id%b d%h e0",
                     rsp_valid, rsp_id, rsp_data, rsp_err, gid, res);
        end
        checks++;
        if ({eng_in_valid, eng_in_data_1, eng_in_data_2} !== {1'b0, exp_ops}) begin
            errors++; $display("FAIL resp_ops got=%h exp=%h", {eng_in_data_1, eng_in_data_2}, exp_ops);
        end
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err, eng_in_valid, eng_in_data_1, eng_in_data_2} !== '0) begin
            errors++;
            $display("FAIL idle_clear got=v%b id%b d%h e%b ops=%h", rsp_valid, rsp_id,
                     rsp_data, rsp_err, {eng_in_data_1, eng_in_data_2});
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, eng_in_valid, eng_in_data_1, eng_in_data_2,
             rsp_valid, rsp_id, rsp_data, rsp_err} !== '0) begin
            errors++; $display("FAIL reset_outputs got nonzero output during reset");
        end
        @(negedge clk);
        rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        m_last = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, eng_in_valid, rsp_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_release got=%b exp=0000",
                               {req0_ready, req1_ready, eng_in_valid, rsp_valid});
        end
    endtask

    task automatic test_alternate();
        int g;
        int exp_seq [4] = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, 1'b1, 10'(i + 1), 3'(i), 10'(i + 100), 3'(i + 4),
                   2, 1'b0, 1'b1, 20'(i * 7 + 3), g);
            checks++;
            if (g !== exp_seq[i]) begin
                errors++; $display("FAIL alternate idx=%0d got=%0d exp=%0d", i, g, exp_seq[i]);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single();
        int g;
        run_op(1'b1, 1'b0, 10'd16, 3'd2, 10'd0, 3'd0, SINGLE_LAT, 1'b0, 1'b0, 20'h00080, g);
        checks++;
        if (g !== 0) begin
            errors++; $display("FAIL single_id got=%0d exp=0", g);
        end
    endtask

    task automatic test_spurious();
        int g;
        req0_valid = 1'b0; req1_valid = 1'b0;
        eng_out_valid = 1'b1; eng_out_data = 20'hABCDE;
        @(negedge clk);
        eng_out_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({rsp_valid, eng_in_valid} !== 2'b00) begin
                errors++; $display("FAIL spurious cyc=%0d got=%b exp=00", i, {rsp_valid, eng_in_valid});
            end
            @(negedge clk);
        end
        run_op(1'b0, 1'b1, 10'd81, 3'd4, 10'd81, 3'd4, 3, 1'b0, 1'b0, 20'h00003, g);
    endtask

    task automatic test_cancel();
        int g;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++; $display("FAIL cancel_ready got=%b exp=10", {req1_ready, req0_ready});
        end
        req1_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (eng_in_valid !== 1'b0) begin
            errors++; $display("FAIL cancel_no_issue got=%b exp=0", eng_in_valid);
        end
        run_op(1'b1, 1'b1, 10'd27, 3'd3, 10'd64, 3'd6, 2, 1'b0, 1'b0, 20'h00042, g);
    endtask

    task automatic test_random();
        int g;
        logic [1:0] v;
        for (int n = 0; n < 24; n++) begin
            v = 2'($urandom_range(1, 3));
            run_op(v[0], v[1], 10'($urandom), 3'($urandom), 10'($urandom), 3'($urandom),
                   $urandom_range(1, 8), 1'($urandom), 1'($urandom), 20'($urandom), g);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int g;
        req0_valid = 1'b1; req0_data_1 = 10'd5; req0_data_2 = 3'd3; req1_valid = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        m_last = 0;
        @(negedge clk);
        @(negedge clk);
        req1_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, eng_in_valid, eng_in_data_1, eng_in_data_2,
             rsp_valid, rsp_id, rsp_data, rsp_err} !== '0) begin
            errors++; $display("FAIL reset_mid_outputs got nonzero output during reset");
        end
        @(negedge clk);
        rst_n = 1'b1; req1_valid = 1'b0;
        m_last = 1;
        eng_out_valid = 1'b1; eng_out_data = 20'h12345;
        @(negedge clk);
        eng_out_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({rsp_valid, eng_in_valid} !== 2'b00) begin
                errors++; $display("FAIL late_result cyc=%0d got=%b exp=00", i, {rsp_valid, eng_in_valid});
            end
            @(negedge clk);
        end
        run_op(1'b1, 1'b1, 10'd100, 3'd2, 10'd200, 3'd3, 4, 1'b0, 1'b0, 20'h0000A, g);
        checks++;
        if (g !== 0) begin
            errors++; $display("FAIL reset_mid_tie got=%0d exp=0", g);
        end
    endtask

    task automatic test_timeout();
`ifdef ROOT_ARB_TIMEOUT_EN
        int g;
        logic [19:0] exp_d;
        for (int s = 0; s < 2; s++) begin
            req1_valid = 1'b1; req1_data_1 = 10'd9; req1_data_2 = 3'd2; req0_valid = 1'b0;
            g = model_grant(1'b0, 1'b1);
            m_last = g;
            @(negedge clk);
            req1_valid = 1'b0;
            #1;
            checks++;
            if (eng_in_valid !== 1'b1) begin
                errors++; $display("FAIL to_issue got=%b exp=1", eng_in_valid);
            end
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk); #1;
                checks++;
                if (rsp_valid !== 1'b0) begin
                    errors++; $display("FAIL to_early scen=%0d cyc=%0d got=%b exp=0", s, i, rsp_valid);
                end
                if (s == 1 && i == 10) begin
                    eng_out_valid = 1'b1; eng_out_data = 20'h00003;
                end
            end
            @(negedge clk);
            eng_out_valid = 1'b0;
            #1;
            exp_d = (s == 1) ? 20'h00003 : 20'h0;
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 1'b1, exp_d, (s == 0)}) begin
                errors++;
                $display("FAIL to_resp scen=%0d got=v%b id%b d%h e%b exp=v1 id1 d%h e%0d",
                         s, rsp_valid, rsp_id, rsp_data, rsp_err, exp_d, (s == 0));
            end
            @(negedge clk); #1;
            checks++;
            if ({rsp_valid, rsp_err, rsp_data} !== '0) begin
                errors++; $display("FAIL to_clear scen=%0d got=v%b e%b", s, rsp_valid, rsp_err);
            end
        end
`else
        req1_valid = 1'b1; req1_data_1 = 10'd9; req1_data_2 = 3'd2; req0_valid = 1'b0;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            checks++;
            if ({rsp_valid, req0_ready, eng_in_valid} !== 3'b000) begin
                errors++; $display("FAIL stuck_wait cyc=%0d got=%b exp=000", i,
                                   {rsp_valid, req0_ready, eng_in_valid});
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 1;
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data_1 = '0; req0_data_2 = '0;
        req1_data_1 = '0; req1_data_2 = '0;
        eng_out_valid = 1'b0; eng_out_data = '0;
        test_reset();
        test_alternate();
        test_single();
        test_spurious();
        test_cancel();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
